// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and parity helpers for the buffered duplex UART.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic logic parity_enabled(input parity_e mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Callers zero-extend the payload to 9 bits, so the XOR covers exactly DATA_BITS.
    function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_duplex_fifo_channel_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_duplex_fifo_channel_if
// Brief    : FIFO-side bus of the UART channel (TX write port, RX read port).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_duplex_fifo_channel_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 tx_wr_en;
    logic [DATA_BITS-1:0] tx_wr_data;
    logic                 tx_full;
    logic [CW-1:0]        tx_count;
    logic                 rx_rd_en;
    logic [DATA_BITS-1:0] rx_rd_data;
    logic                 rx_empty;
    logic [CW-1:0]        rx_count;

    modport master (
        output tx_wr_en, tx_wr_data, rx_rd_en,
        input  tx_full, tx_count, rx_rd_data, rx_empty, rx_count
    );

    modport slave (
        input  tx_wr_en, tx_wr_data, rx_rd_en,
        output tx_full, tx_count, rx_rd_data, rx_empty, rx_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A pop frees the slot being written, so full+read+write is accepted.
    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_duplex_fifo_channel.sv
`default_nettype none
// ============================================================================
// Module   : uart_duplex_fifo_channel
// Brief    : Full-duplex UART endpoint with TX/RX FIFOs, parity, errors, loopback.
// Revision : 1.0 - initial release
// ============================================================================
module uart_duplex_fifo_channel
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_duplex_fifo_channel_if.slave    bus,
    input  logic [1:0]                   parity_mode,
    input  logic                         loopback,
    input  logic                         err_clr,
    input  logic                         rx_serial_in,
    output logic                         tx_serial_out,
    output logic                         tx_busy,
    output logic                         tx_done,
    output logic                         rx_done,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overrun_err
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_HALF_BIT   = CLKS_PER_BIT / 2;
    localparam int c_CNT_W      = $clog2(CLKS_PER_BIT + 1);
    localparam int c_BIT_W      = $clog2(DATA_BITS + 1);

    // ---------------- TX path ----------------
    tx_state_e              r_tx_state, w_tx_next;
    logic [c_CNT_W-1:0]     r_tx_cnt;
    logic [c_BIT_W-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0]   r_tx_shift;
    parity_e                r_tx_mode;
    logic                   r_tx_par;
    logic [DATA_BITS-1:0]   w_tx_head;
    logic                   w_tx_empty;
    logic                   w_tx_pop;
    logic                   w_tx_done;
    logic                   w_tx_line;
    logic                   w_tx_tick;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.tx_wr_en),
        .i_wr_data (bus.tx_wr_data),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_full    (bus.tx_full),
        .o_empty   (w_tx_empty),
        .o_count   (bus.tx_count)
    );

    assign w_tx_tick = (r_tx_cnt == c_CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        w_tx_done = 1'b0;
        w_tx_line = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = TX_START;
                end
            end
            TX_START: begin
                w_tx_line = 1'b0;
                if (w_tx_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_tick && (r_tx_bit == c_BIT_W'(DATA_BITS - 1)))
                    w_tx_next = parity_enabled(r_tx_mode) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_tx_line = r_tx_par;
                if (w_tx_tick) w_tx_next = TX_STOP;
            end
            TX_STOP: begin
                // Chain straight into the next START when more data is queued.
                if (w_tx_tick && (r_tx_bit == c_BIT_W'(STOP_BITS - 1))) begin
                    w_tx_done = 1'b1;
                    if (!w_tx_empty) begin
                        w_tx_pop  = 1'b1;
                        w_tx_next = TX_START;
                    end else begin
                        w_tx_next = TX_IDLE;
                    end
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_mode  <= PAR_NONE;
            r_tx_par   <= 1'b0;
        end else begin
            if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_cnt <= '0;
            else                                    r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
            if (w_tx_tick)
                r_tx_bit <= (w_tx_next != r_tx_state) ? '0 : r_tx_bit + c_BIT_W'(1);
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_mode  <= parity_e'(parity_mode);
                r_tx_par   <= calc_parity(9'(w_tx_head), parity_e'(parity_mode));
            end else if (r_tx_state == TX_DATA && w_tx_tick) begin
                r_tx_shift <= r_tx_shift >> 1;
            end
        end
    end

    assign tx_serial_out = loopback ? 1'b1 : w_tx_line;
    assign tx_busy       = (r_tx_state != TX_IDLE);
    assign tx_done       = w_tx_done;

    // ---------------- RX path ----------------
    rx_state_e              r_rx_state, w_rx_next;
    logic [1:0]             r_sync;
    logic                   r_rx_prev;
    logic [c_CNT_W-1:0]     r_rx_cnt;
    logic [c_BIT_W-1:0]     r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    parity_e                r_rx_mode;
    logic                   r_rx_par_bad;
    logic                   r_parity_err, r_frame_err, r_overrun_err;
    logic                   w_rx_pin, w_rx_line, w_rx_fall, w_rx_tick, w_rx_full;
    logic                   w_rx_push, w_set_parity, w_set_frame, w_set_overrun;

    assign w_rx_pin  = loopback ? w_tx_line : rx_serial_in;
    assign w_rx_line = r_sync[1];
    assign w_rx_fall = r_rx_prev && !w_rx_line;
    assign w_rx_tick = (r_rx_state == RX_START) ? (r_rx_cnt == c_CNT_W'(c_HALF_BIT - 1))
                                                : (r_rx_cnt == c_CNT_W'(CLKS_PER_BIT - 1));

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_rx_push),
        .i_wr_data (r_rx_shift),
        .i_rd_en   (bus.rx_rd_en),
        .o_rd_data (bus.rx_rd_data),
        .o_full    (w_rx_full),
        .o_empty   (bus.rx_empty),
        .o_count   (bus.rx_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_push     = 1'b0;
        w_set_parity  = 1'b0;
        w_set_frame   = 1'b0;
        w_set_overrun = 1'b0;
        case (r_rx_state)
            RX_IDLE:   if (w_rx_fall) w_rx_next = RX_START;
            RX_START:  if (w_rx_tick) w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (w_rx_tick && (r_rx_bit == c_BIT_W'(DATA_BITS - 1)))
                    w_rx_next = parity_enabled(r_rx_mode) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (w_rx_tick) w_rx_next = RX_STOP;
            RX_STOP: begin
                // Leave at the stop-bit centre so the next start edge is not missed.
                if (w_rx_tick) begin
                    w_rx_next = RX_IDLE;
                    if (!w_rx_line) begin
                        w_set_frame = 1'b1;
                    end else if (w_rx_full && !bus.rx_rd_en) begin
                        w_set_overrun = 1'b1;
                    end else begin
                        w_rx_push    = 1'b1;
                        w_set_parity = r_rx_par_bad;
                    end
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync        <= 2'b11;
            r_rx_prev     <= 1'b1;
            r_rx_cnt      <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_mode     <= PAR_NONE;
            r_rx_par_bad  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], w_rx_pin};
            r_rx_prev <= w_rx_line;
            if (r_rx_state == RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
            else                                    r_rx_cnt <= r_rx_cnt + c_CNT_W'(1);
            if (w_rx_tick)
                r_rx_bit <= (w_rx_next != r_rx_state) ? '0 : r_rx_bit + c_BIT_W'(1);
            if (r_rx_state == RX_IDLE && w_rx_fall) begin
                r_rx_mode    <= parity_e'(parity_mode);
                r_rx_par_bad <= 1'b0;
            end
            if (r_rx_state == RX_DATA && w_rx_tick)
                r_rx_shift <= {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_state == RX_PARITY && w_rx_tick)
                r_rx_par_bad <= (w_rx_line != calc_parity(9'(r_rx_shift), r_rx_mode));
            // Sticky flags: a set event in the same cycle as err_clr wins.
            if (w_set_parity)  r_parity_err  <= 1'b1; else if (err_clr) r_parity_err  <= 1'b0;
            if (w_set_frame)   r_frame_err   <= 1'b1; else if (err_clr) r_frame_err   <= 1'b0;
            if (w_set_overrun) r_overrun_err <= 1'b1; else if (err_clr) r_overrun_err <= 1'b0;
        end
    end

    assign rx_done     = w_rx_push;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
endmodule
`default_nettype wire

// File: doc/uart_duplex_fifo_channel.md
Name: uart_duplex_fifo_channel

Overview:
- One full-duplex UART endpoint: parametrised data width, parity mode, stop bits, TX and RX buffering through FIFOs, error reporting and internal loopback.
- Two instances cross-connected (tx_serial_out of one to rx_serial_in of the other) form the buffered successor of the current A/B full-duplex link.
- The link top instantiates it once per side.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- BAUD_RATE, 19200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide).
- DATA_BITS, 8, payload bits per frame. Legal range 5..9.
- FIFO_DEPTH, 16, entries per FIFO. Must be a power of 2 and at least 2. CW = $clog2(FIFO_DEPTH)+1.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tx_wr_en  in  1  push tx_wr_data into the TX FIFO
- tx_wr_data  in  DATA_BITS  payload to transmit
- tx_full  out  1  TX FIFO full
- tx_count  out  CW  TX FIFO occupancy
- rx_rd_en  in  1  pop the RX FIFO head
- rx_rd_data  out  DATA_BITS  RX FIFO head (first-word fall-through)
- rx_empty  out  1  RX FIFO empty
- rx_count  out  CW  RX FIFO occupancy
- parity_mode  in  2  0 = none, 1 = even, 2 = odd, 3 = none
- loopback  in  1  route TX serial output internally to the RX path
- err_clr  in  1  clear all sticky error flags
- rx_serial_in  in  1  serial input (asynchronous)
- tx_serial_out  out  1  serial output, idle high
- tx_busy  out  1  TX frame in progress
- tx_done  out  1  one-cycle pulse at the end of the last stop bit
- rx_done  out  1  one-cycle pulse when a frame is accepted into the RX FIFO
- parity_err, frame_err, overrun_err  out  1 each  sticky error flags

Behaviour:
- Reset values: tx_serial_out = 1; all other outputs 0 except rx_empty = 1. FIFOs empty, both FSMs in IDLE.
- Reset asserted mid-frame aborts the frame: tx_serial_out is 1 from the reset edge onward.
- FIFO rules:
  - A write when full is ignored; a read when empty is ignored.
  - Simultaneous read and write on a full FIFO: both accepted, count unchanged.
  - Simultaneous read and write on an empty FIFO: write accepted, read ignored.
  - rx_rd_data is valid whenever rx_empty = 0.
- TX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
  - In IDLE with the TX FIFO non-empty, the next cycle enters START. The FIFO pop and capture of parity_mode happen on that edge.
  - Each state lasts CLKS_PER_BIT cycles per bit. DATA is sent LSB first.
  - PARITY is skipped when the mode is none. Even parity makes the total number of ones (data + parity) even; odd makes it odd.
  - STOP lasts STOP_BITS bit periods. tx_done pulses in the final cycle of STOP.
  - Frames go back-to-back, with no idle gap when the FIFO still holds data.
  - tx_busy = 1 whenever the FSM is not in IDLE.
- RX path: rx_serial_in passes through a 2-flop synchroniser. In loopback the RX path sees the internal TX line, the pin input is ignored, and tx_serial_out is held at 1.
- RX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
  - A falling edge in IDLE enters START. The line is re-checked after CLKS_PER_BIT/2 cycles; if it is high, the FSM returns to IDLE (glitch reject).
  - Subsequent samples are taken every CLKS_PER_BIT cycles, at bit centres.
  - parity_mode is captured at start detection.
  - Only the first stop bit is checked. The FSM returns to IDLE at the stop-bit centre so the next start bit is caught.
- At the stop-bit sample, exactly one of:
  - Stop bit = 0: frame_err is set and the frame is dropped.
  - Otherwise, RX FIFO full and no pop in the same cycle: overrun_err is set, the frame is dropped and FIFO contents are preserved.
  - Otherwise: the frame is pushed and rx_done pulses in the same cycle. A parity mismatch sets parity_err but the frame is still pushed.
- Error flags stay set until err_clr or rst. If a set event and err_clr occur in the same cycle, set wins.

Decomposition:
- Package uart_pkg holds:
  - parity_e (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD)
  - tx_state_e and rx_state_e
  - a function computing parity over DATA_BITS
- One sub-module, uart_sync_fifo (parameters WIDTH, DEPTH), instantiated twice. It is FWFT and exposes full, empty and count.
- Baud counters stay inline in the TX and RX FSMs.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT = 16.
1. Loopback, parity none, write 0xA5 -> tx_done 160 cycles after START entry; rx_done then fires; rx_rd_data = 0xA5 and rx_count = 1; tx_serial_out stays 1 throughout.
2. Two instances cross-connected, even parity:
   - Stimulus: A bursts 0x00, 0xFF, 0x55, 0x81 while B sends 0x3C, 0xC3 at the same time.
   - Required: each side receives its bytes in order with no errors.
   - Required: A's frames run back-to-back, 176 cycles apart.
3. Drive rx_serial_in with 0x03, even parity, parity bit 1 -> parity_err = 1 and 0x03 is pushed; err_clr for one cycle -> parity_err = 0.
4. Frame with stop bit 0 -> frame_err = 1, rx_count unchanged, no rx_done.
5. Receive 16 frames without reading, then a 17th -> overrun_err = 1, rx_count = 16, head is still the first byte. Repeat with rx_rd_en asserted at the 17th stop sample -> frame accepted and no overrun.
6. A 4-cycle low glitch on an idle line -> no reception. Assert rst at bit 3 of a TX frame -> tx_serial_out = 1 immediately, FIFOs empty, tx_busy = 0.
